rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Upstream feeder for the dual-port ROM macro in the CBM-II core.
- Takes the MiSTer ioctl download byte stream and selects one file by index and one address window within it.
- Turns accepted bytes into single-cycle write strokes on the ROM's write port.
- After the download ends, pads the unwritten tail with a fill byte and flags the ROM as loaded.

Parameters:
- ADDRWIDTH, 14, ROM address width; window size is 2^ADDRWIDTH bytes.
- INDEX, 8'd0, ioctl_index value this instance responds to.
- PAD_BYTE, 8'hFF, fill value for ROM bytes not covered by the download.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the whole download.
- ioctl_index  in  8  file index of the current download.
- ioctl_addr  in  25  byte address within the file.
- ioctl_dout  in  8  download data byte.
- ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_dout valid.
- ioctl_wait  out  1  back-pressure to the HPS; high while a byte is held.
- base_addr  in  25  file offset mapped to ROM address 0; static during a download.
- rom_addr  out  ADDRWIDTH  ROM write address.
- rom_data  out  8  ROM write data.
- rom_wren  out  1  ROM write enable, one cycle per byte.
- busy  out  1  load or pad in progress.
- loaded  out  1  sticky; ROM fully initialised.
- overflow  out  1  sticky; a byte at or above base_addr+2^ADDRWIDTH was dropped.

Behaviour:
- Reset: state IDLE; rom_addr, rom_data, rom_wren, ioctl_wait, busy, loaded and overflow all 0; high-water counter hw (ADDRWIDTH+1 bits) = 0.
- States:
  - IDLE -> LOAD when ioctl_download=1 and ioctl_index==INDEX. On entry: clear hw, loaded, overflow; set busy=1.
  - Downloads with any other index are ignored completely; no state change, no outputs.
- LOAD, byte acceptance:
  - ioctl_wr at cycle N with base_addr <= ioctl_addr < base_addr+2^ADDRWIDTH: offset = ioctl_addr-base_addr (low ADDRWIDTH bits).
  - Cycle N+1: rom_addr=offset, rom_data=ioctl_dout, rom_wren=1 for exactly one cycle.
  - hw = max(hw, offset+1). Out-of-order addresses are allowed; each byte is written where it lands.
- ioctl_wait:
  - High in cycle N+1, i.e. while the single-entry holding register is full.
  - A strobe arriving while the holder is full overwrites nothing and is dropped. That is an HPS protocol error; no flag is raised.
- Out-of-window bytes:
  - ioctl_addr < base_addr: silently ignored.
  - ioctl_addr >= base_addr+2^ADDRWIDTH: ignored and overflow=1.
  - No rom_wren in either case.
- LOAD -> PAD:
  - Taken on ioctl_download falling, after any pending write has issued.
  - If hw == 2^ADDRWIDTH, go straight to DONE.
- PAD: one write per cycle, rom_addr = hw, hw+1, ..., 2^ADDRWIDTH-1, rom_data=PAD_BYTE, rom_wren=1 continuously.
- DONE, single cycle: loaded=1, busy=0, -> IDLE. loaded stays high until the next matching download or reset.
- Zero-length download: pads the whole ROM, 2^ADDRWIDTH writes.
- Matching ioctl_download re-asserted during PAD: abort the pad, restart LOAD with the entry actions. loaded stays 0.
- Reset mid-operation: immediate return to reset values. ROM contents are undefined and loaded=0.

Optional Feature:
- Macro ROM_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output checksum [15:0] = sum modulo 2^16 of all accepted in-window download bytes; pad bytes excluded.
  - Cleared on LOAD entry. Valid while loaded=1.
- Undefined: no checksum port and no accumulator logic.

Decomposition:
- Shared package cbm2_rom_pkg holds:
  - ioctl index constants (ROM_IDX_BASIC, ROM_IDX_KERNAL, ROM_IDX_CHAR).
  - Default PAD_BYTE.
  - typedef enum rom_loader_state_t {IDLE, LOAD, PAD, DONE}.
- No sub-module required. The window compare, holder and pad counter fit in one module.

Test Plan:
- Reset asserted for 2 cycles mid-LOAD -> all outputs 0 the following cycle; no rom_wren afterwards.
- ADDRWIDTH=4, base 0x10, 16 bytes at 0x10..0x1F with data = addr^0xA5 -> 16 rom_wren pulses, addr 0..F, data 0xB5..0xBA pattern, each at N+1; no pad writes; loaded=1.
- Same setup, 5 bytes at 0x10..0x14 then download falls -> 5 data writes, then 11 consecutive writes of 0xFF at addr 5..15, then loaded=1 and busy=0.
- Bytes at 0x0F and 0x20 -> no rom_wren for either; overflow=1 only after 0x20.
- Download with index 3 (INDEX=0) -> busy stays 0, no rom_wren, loaded unchanged. Re-assert a matching download during PAD -> pad stops that cycle and busy stays 1.
- CHECKSUM_EN: bytes 0x80, 0x90, 0xF0 -> checksum=0x0200 at loaded=1; pad bytes do not change it.

Source files
------------

// File: rtl/cbm2_rom_pkg.sv
// ============================================================================
// Module : cbm2_rom_pkg
// Brief  : Shared constants and types for the CBM-II ROM download path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cbm2_rom_pkg;

  localparam logic [7:0] ROM_IDX_BASIC  = 8'd0;
  localparam logic [7:0] ROM_IDX_KERNAL = 8'd1;
  localparam logic [7:0] ROM_IDX_CHAR   = 8'd2;

  localparam logic [7:0] c_default_pad_byte = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } rom_loader_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_loader.sv
// ============================================================================
// Module : rom_loader
// Brief  : Maps one ioctl download file window onto a ROM write port, then
//          pads the unwritten tail. Optional checksum: ROM_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_loader
  import cbm2_rom_pkg::*;
#(
  parameter int         ADDRWIDTH = 14,
  parameter logic [7:0] INDEX     = 8'd0,
  parameter logic [7:0] PAD_BYTE  = c_default_pad_byte
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 ioctl_wr,
  output logic                 ioctl_wait,
  input  logic [24:0]          base_addr,
  output logic [ADDRWIDTH-1:0] rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wren,
  output logic                 busy,
  output logic                 loaded,
  output logic                 overflow
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  localparam logic [ADDRWIDTH:0] c_hw_full = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] c_hw_one  = {{ADDRWIDTH{1'b0}}, 1'b1};

  rom_loader_state_t    r_state;
  logic [ADDRWIDTH:0]   r_hw;

  logic [24:0]          w_diff;
  logic                 w_below;
  logic                 w_in_win;
  logic                 w_above;
  logic [ADDRWIDTH:0]   w_off_p1;
  logic                 w_match;
  logic                 w_accept;

  // Subtracting first avoids base_addr + window overflowing 25 bits.
  assign w_diff   = ioctl_addr - base_addr;
  assign w_below  = (ioctl_addr < base_addr);
  assign w_in_win = !w_below && ((w_diff >> ADDRWIDTH) == 25'd0);
  assign w_above  = !w_below && !w_in_win;
  assign w_off_p1 = {1'b0, w_diff[ADDRWIDTH-1:0]} + c_hw_one;
  assign w_match  = ioctl_download && (ioctl_index == INDEX);
  // The output register doubles as the one-entry holder; ioctl_wait marks it full.
  assign w_accept = ioctl_wr && !ioctl_wait;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hw       <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
      rom_wren   <= 1'b0;
      ioctl_wait <= 1'b0;
      busy       <= 1'b0;
      loaded     <= 1'b0;
      overflow   <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      rom_wren   <= 1'b0;
      ioctl_wait <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_match) begin
            r_state  <= LOAD;
            r_hw     <= '0;
            loaded   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (!ioctl_download) begin
            if (r_hw == c_hw_full) begin
              r_state <= DONE;
              loaded  <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state <= PAD;
            end
          end else if (w_accept) begin
            if (w_in_win) begin
              rom_addr   <= w_diff[ADDRWIDTH-1:0];
              rom_data   <= ioctl_dout;
              rom_wren   <= 1'b1;
              ioctl_wait <= 1'b1;
              if (w_off_p1 > r_hw) r_hw <= w_off_p1;
`ifdef ROM_LOADER_CHECKSUM_EN
              checksum   <= checksum + {8'd0, ioctl_dout};
`endif
            end else if (w_above) begin
              overflow <= 1'b1;
            end
          end
        end
        PAD: begin
          if (w_match) begin
            r_state  <= LOAD;
            r_hw     <= '0;
            loaded   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end else if (r_hw == c_hw_full) begin
            r_state <= DONE;
            loaded  <= 1'b1;
            busy    <= 1'b0;
          end else begin
            rom_addr <= r_hw[ADDRWIDTH-1:0];
            rom_data <= PAD_BYTE;
            rom_wren <= 1'b1;
            r_hw     <= r_hw + c_hw_one;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
// Module : tb_rom_loader
// Brief  : Scoreboard bench for rom_loader, 16-byte window at file offset 0x10.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [24:0] base_addr;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        rom_wren;
  logic        busy;
  logic        loaded;
  logic        overflow;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] sb_q[$];

  always #5 clock = ~clock;

  rom_loader #(.ADDRWIDTH(4), .INDEX(8'd0), .PAD_BYTE(8'hFF)) dut (
    .clock          (clock),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .base_addr      (base_addr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_wren       (rom_wren),
    .busy           (busy),
    .loaded         (loaded),
    .overflow       (overflow)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Every ROM write must match the oldest expected (addr,data) pair.
  always @(negedge clock) begin
    if (rom_wren === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wren", {28'd0, rom_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = sb_q.pop_front();
        check("wr_addr", {28'd0, rom_addr}, {28'd0, e[11:8]});
        check("wr_data", {24'd0, rom_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input logic exp_wr);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    check("wren_n1", {31'd0, rom_wren}, {31'd0, exp_wr});
    check("wait_n1", {31'd0, ioctl_wait}, {31'd0, exp_wr});
    tick();
  endtask

  task automatic push_pads(input int from);
    for (int i = from; i < 16; i++) sb_q.push_back({4'(i), 8'hFF});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (loaded === 1'b1 && busy === 1'b0) break;
      tick();
    end
    check("done_loaded", {31'd0, loaded}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0; base_addr = 25'h10;
    tick(); tick();
    check("rst_outs", {26'd0, rom_wren, ioctl_wait, busy, loaded, overflow, 1'b0},
          32'd0);
    check("rst_addr_data", {20'd0, rom_addr, rom_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Full window, no padding expected.
    start_dl(8'd0);
    check("entry_busy", {31'd0, busy}, 32'd1);
    for (int a = 16; a < 32; a++) begin
      logic [7:0] d;
      d = 8'(a) ^ 8'hA5;
      sb_q.push_back({4'(a - 16), d});
      write_byte(25'(a), d, 1'b1);
    end
    ioctl_download = 1'b0;
    wait_done();
    check("full_ovf", {31'd0, overflow}, 32'd0);

    // Non-matching index is ignored completely.
    start_dl(8'd3);
    write_byte(25'h10, 8'h55, 1'b0);
    check("idx3_busy", {31'd0, busy}, 32'd0);
    check("idx3_loaded", {31'd0, loaded}, 32'd1);
    ioctl_download = 1'b0;
    tick(); tick();
    check("idx3_loaded2", {31'd0, loaded}, 32'd1);

    // Partial load then pad tail.
    start_dl(8'd0);
    check("reentry_loaded", {31'd0, loaded}, 32'd0);
    for (int a = 16; a < 21; a++) begin
      logic [7:0] d;
      d = 8'(a) ^ 8'hA5;
      sb_q.push_back({4'(a - 16), d});
      write_byte(25'(a), d, 1'b1);
    end
    push_pads(5);
    ioctl_download = 1'b0;
    wait_done();

    // Window edges.
    start_dl(8'd0);
    write_byte(25'h0F, 8'h11, 1'b0);
    check("below_ovf", {31'd0, overflow}, 32'd0);
    write_byte(25'h20, 8'h22, 1'b0);
    check("above_ovf", {31'd0, overflow}, 32'd1);
    push_pads(0);
    ioctl_download = 1'b0;
    wait_done();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Abort a pad by re-asserting a matching download.
    start_dl(8'd0);
    sb_q.push_back({4'd0, 8'h3C});
    write_byte(25'h10, 8'h3C, 1'b1);
    push_pads(1);
    ioctl_download = 1'b0;
    repeat (6) tick();
    check("pad_running", {31'd0, rom_wren}, 32'd1);
    ioctl_download = 1'b1;
    tick();
    check("abort_wren", {31'd0, rom_wren}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_loaded", {31'd0, loaded}, 32'd0);
    sb_q.delete();
    repeat (3) tick();
    check("abort_busy2", {31'd0, busy}, 32'd1);
    push_pads(0);
    ioctl_download = 1'b0;
    wait_done();

`ifdef ROM_LOADER_CHECKSUM_EN
    start_dl(8'd0);
    sb_q.push_back({4'd0, 8'h80}); write_byte(25'h10, 8'h80, 1'b1);
    sb_q.push_back({4'd1, 8'h90}); write_byte(25'h11, 8'h90, 1'b1);
    sb_q.push_back({4'd2, 8'hF0}); write_byte(25'h12, 8'hF0, 1'b1);
    push_pads(3);
    ioctl_download = 1'b0;
    wait_done();
    check("checksum", {16'd0, checksum}, 32'h0200);
`endif

    // Reset in the middle of a load.
    start_dl(8'd0);
    sb_q.push_back({4'd3, 8'h77});
    write_byte(25'h13, 8'h77, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick(); tick();
    check("mid_rst_outs", {27'd0, rom_wren, ioctl_wait, busy, loaded, overflow}, 32'd0);
    check("mid_rst_addr", {20'd0, rom_addr, rom_data}, 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_loaded", {31'd0, loaded}, 32'd0);
    check("post_rst_sb", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
